// File: rtl/uart_rx.sv
// 8N1 serial receiver, oversampled on clk; pairs with uart_tx for loopback.
// Define UART_RX_PARITY_EN to expect one even-parity bit before the stop bit.
module uart_rx #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_error,
   output logic                 parity_error,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;

   logic [2:0]           state;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 rx_meta;
   logic                 rx_s;
   logic                 par_bad;

   // Two-flop synchronizer; resets to the idle level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_bad <= 1'b0;
      end else if (state == S_PARITY && cnt == BIT_LAST) begin
         par_bad <= (^shreg) ^ rx_s;
      end
   end
`else
   assign par_bad = 1'b0;
`endif

   // Strobes default low every cycle so each fires for exactly one cycle per frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         idx          <= '0;
         shreg        <= '0;
         data         <= '0;
         valid        <= 1'b0;
         frame_error  <= 1'b0;
         parity_error <= 1'b0;
      end else begin
         valid        <= 1'b0;
         frame_error  <= 1'b0;
         parity_error <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (!rx_s) state <= S_START;
            end
            S_START: begin
               if (cnt == HALF_LAST) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  state <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            S_STOP: begin
               // Leave at mid-stop-bit so a back-to-back start edge is not missed.
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     frame_error <= 1'b1;
                     state       <= S_BREAK;
                  end else if (par_bad) begin
                     parity_error <= 1'b1;
                     state        <= S_IDLE;
                  end else begin
                     data  <= shreg;
                     valid <= 1'b1;
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_BREAK: begin
               if (rx_s) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: serial frames are generated here and the expected
// strobes (kind, data, cycle) come from a frame-level model of the receiver.
module tb_uart_rx;

   localparam int DB = 8;
   localparam int C  = 32;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int LATENCY = 2 + C / 2 + (DB + 1 + PB) * C;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx;
   logic [DB-1:0] data;
   logic          valid;
   logic          frame_error;
   logic          parity_error;
   logic          busy;

   typedef struct {
      int            kind;
      logic [DB-1:0] d;
      int            cyc;
   } ev_t;

   ev_t           expQ[$];
   ev_t           actQ[$];
   int            cyc = 0;
   int            compared = 0;
   int            mismatched = 0;
   logic [DB-1:0] lastGood = '0;

   uart_rx #(.DATA_BITS(DB), .CLKS_PER_BIT(C)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .data(data),
      .valid(valid),
      .frame_error(frame_error),
      .parity_error(parity_error),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every high strobe becomes one event; a long or doubled pulse shows up as extra events.
   always @(negedge clk) begin
      if (valid)        actQ.push_back('{0, data, cyc});
      if (frame_error)  actQ.push_back('{1, data, cyc});
      if (parity_error) actQ.push_back('{2, data, cyc});
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic holdBit(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends one frame starting #1 after a posedge and records the outcome the receiver should report.
   task automatic applyStimulus(input logic [DB-1:0] d, input bit parBad, input bit stopBad,
                                input int lowExtra, input int gap);
      ev_t e;
      e.cyc = cyc + 1 + LATENCY;
      holdBit(1'b0, C);
      for (int i = 0; i < DB; i++) holdBit(d[i], C);
      if (PB == 1) holdBit((^d) ^ parBad, C);
      if (stopBad) begin
         holdBit(1'b0, C + lowExtra);
         e.kind = 1;
         e.d    = lastGood;
      end else begin
         holdBit(1'b1, C);
         if (PB == 1 && parBad) begin
            e.kind = 2;
            e.d    = lastGood;
         end else begin
            e.kind   = 0;
            e.d      = d;
            lastGood = d;
         end
      end
      expQ.push_back(e);
      if (gap > 0) holdBit(1'b1, gap);
   endtask

   task automatic checkBurst(input string tag);
      holdBit(1'b1, 4);
      checkOutput({tag, "_count"}, actQ.size(), expQ.size());
      for (int i = 0; i < expQ.size(); i++) begin
         if (i < actQ.size()) begin
            checkOutput({tag, "_kind"}, actQ[i].kind, expQ[i].kind);
            checkOutput({tag, "_data"}, 32'(actQ[i].d), 32'(expQ[i].d));
            checkOutput({tag, "_cycle"}, actQ[i].cyc, expQ[i].cyc);
         end
      end
      checkOutput({tag, "_busy_idle"}, busy, 1'b0);
      checkOutput({tag, "_data_hold"}, 32'(data), 32'(lastGood));
      expQ.delete();
      actQ.delete();
   endtask

   initial begin
      int e0;
      int len;
      logic [DB-1:0] d;
      bit sb;
      bit pb;

      rx  = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_data", 32'(data), 32'h0);
      checkOutput("rst_valid", valid, 1'b0);
      checkOutput("rst_frame_error", frame_error, 1'b0);
      checkOutput("rst_parity_error", parity_error, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      rst = 1'b0;
      holdBit(1'b1, 4);

      applyStimulus(8'h5C, 1'b0, 1'b0, 0, C);
      checkBurst("single");

      applyStimulus(8'h5C, 1'b0, 1'b0, 0, 0);
      applyStimulus(8'h5D, 1'b0, 1'b0, 0, 0);
      applyStimulus(8'h5E, 1'b0, 1'b0, 0, 2 * C);
      checkBurst("back2back");

      applyStimulus(8'hA5, 1'b0, 1'b1, 500, C);
      checkBurst("frame_err");

      for (int g = 0; g < 3; g++) begin
         len = $urandom_range(1, 14);
         e0  = cyc + 1;
         holdBit(1'b0, len);
         rx = 1'b1;
         while (cyc < e0 + 16) @(posedge clk);
         #1;
         checkOutput("glitch_busy_high", busy, 1'b1);
         holdBit(1'b1, 4);
         checkOutput("glitch_busy_low", busy, 1'b0);
         checkBurst("glitch");
      end

`ifdef UART_RX_PARITY_EN
      applyStimulus(8'h5C, 1'b0, 1'b0, 0, C);
      applyStimulus(8'h5C, 1'b1, 1'b0, 0, C);
      checkBurst("parity");
`endif

      // Abort 0x5C halfway through data bit 3, then confirm a clean restart.
      d = 8'h5C;
      holdBit(1'b0, C);
      for (int i = 0; i < 3; i++) holdBit(d[i], C);
      holdBit(d[3], C / 2);
      rst = 1'b1;
      holdBit(d[3], 2);
      checkOutput("midrst_data", 32'(data), 32'h0);
      checkOutput("midrst_valid", valid, 1'b0);
      checkOutput("midrst_frame_error", frame_error, 1'b0);
      checkOutput("midrst_parity_error", parity_error, 1'b0);
      checkOutput("midrst_busy", busy, 1'b0);
      lastGood = '0;
      rst = 1'b0;
      holdBit(1'b1, 2 * C);
      applyStimulus(8'h33, 1'b0, 1'b0, 0, C);
      checkBurst("midrst");

      for (int n = 0; n < 16; n++) begin
         d  = DB'($urandom);
         sb = ($urandom_range(0, 5) == 0);
         pb = (PB == 1) && ($urandom_range(0, 3) == 0);
         if (sb) applyStimulus(d, pb, 1'b1, $urandom_range(0, 3 * C), $urandom_range(1, C));
         else    applyStimulus(d, pb, 1'b0, 0, $urandom_range(0, C));
         if (n % 4 == 3) checkBurst("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
